vc_output_arbiter: RTL and testbench
====================================

// Module: vc_output_arbiter
// PURPOSE
//   Round-robin scheduler that shares one router output link between NUM_VC virtual-channel FIFOs.
//   It chooses one non-empty VC per cycle, pops that VC's head flit and registers it onto a valid/ready output.
//   It sits between the per-direction VC buffers and the output port/crossbar of a NoC router.
// PARAMETERS
//   NUM_VC     4   number of virtual-channel FIFOs arbitrated (power of 2, 2..8)
//   DATA_WIDTH 32  flit width in bits
// PORTS
//   clk          in   1                 clock, all logic on rising edge
//   rst          in   1                 reset, synchronous, active-high
//   arb_en       in   1                 1 = new grants allowed; 0 = freeze grants (held flit still drains)
//   vc_empty     in   NUM_VC            per-VC FIFO empty flag
//   vc_rd_data   in   NUM_VC*DATA_WIDTH per-VC head flit (combinational FIFO read), VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vc_rd_en     out  NUM_VC            one-hot pop strobe to the granted VC (combinational)
//   out_valid    out  1                 output register holds a flit
//   out_data     out  DATA_WIDTH        registered flit
//   out_vc       out  $clog2(NUM_VC)    VC index the flit came from
//   out_ready    in   1                 downstream accepts the flit this cycle
// BEHAVIOUR
//   - Output register is a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - req = ~vc_empty.
//   - load = arb_en & |req & (~out_valid | out_ready).
//   - Grant g is the first VC with req=1, searching from (ptr+1) mod NUM_VC upward with wrap.
//   - ptr resets to NUM_VC-1, so VC0 has top priority after reset.
//   - On load:
//       - vc_rd_en[g]=1 in the same cycle.
//       - At the next edge: out_data<=vc_rd_data[g], out_vc<=g, out_valid<=1, ptr<=g.
//   - Else, if out_valid & out_ready: out_valid<=0 at the next edge; out_data and out_vc keep their old values.
//   - vc_rd_en is all-zero when load=0. It is never asserted to an empty VC. At most one bit is set.
//   - Latency: flit visible on out_data 1 cycle after its pop.
//   - Throughput: 1 flit/cycle while out_ready=1; simultaneous drain+load is a back-to-back transfer.
//   - Backpressure: while out_valid & ~out_ready, out_data and out_vc are stable and no pop occurs.
//   - Pointer updates only on a grant. An idle cycle or arb_en=0 leaves ptr unchanged.
//   - Wrap-around: ptr=NUM_VC-1 searches from VC0.
//   - Reset values: out_valid=0, out_data=0, out_vc=0, ptr=NUM_VC-1, vc_rd_en=0.
//   - Reset mid-operation: any flit held in the output register is discarded, not returned to its FIFO.
//     The VC FIFOs must be reset together with this block.
// CONFIGURATION
//   Macro VC_OUTPUT_ARBITER_STATS_EN.
//   - Defined: adds ports
//       stat_clr     in   1
//       stat_grants  out  NUM_VC*16  per-VC grant count, VC i at [i*16 +: 16]
//       stat_stall   out  16         cycles with out_valid & ~out_ready
//     Counters are 16-bit and saturate at 16'hFFFF. Reset value is 0.
//     stat_clr clears them synchronously and takes priority over an increment in the same cycle.
//   - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   - Package noc_pkg holds DATA_WIDTH_DEF=32, NUM_VC_DEF=4, the VC index width function/localparam and the STAT_W=16 constant.
//   - Sub-module rr_arbiter (purely combinational):
//       inputs req[NUM_VC] and ptr
//       outputs one-hot gnt, gnt_idx and any_req
//   - The top level owns the ptr register, the output register/FSM and the optional stats counters.
// TESTING
//   1. Reset, then VC0..VC3 all non-empty, out_ready=1.
//      -> vc_rd_en sequence 0001,0010,0100,1000,0001; out_vc = 0,1,2,3,0 on consecutive cycles.
//   2. Only VC2 holds 3 flits (0xA0,0xA1,0xA2), out_ready=1.
//      -> three back-to-back pops of VC2; out_data = 0xA0,0xA1,0xA2 on consecutive cycles, then out_valid=0.
//   3. out_valid=1 with out_data=0xDEADBEEF, out_ready=0 for 5 cycles, other VCs non-empty.
//      -> out_data stable, vc_rd_en=0 throughout; the next VC is popped in the cycle out_ready returns to 1.
//   4. Grant to VC1, then only VC1 and VC3 non-empty.
//      -> next grant is VC3, then VC1; arb_en=0 stops all pops while the held flit still drains.
//   5. Assert rst while out_valid=1.
//      -> next cycle out_valid=0, out_data=0, out_vc=0; the first grant afterwards goes to the lowest non-empty VC.
//   6. With VC_OUTPUT_ARBITER_STATS_EN, run test 1 for 8 flits plus test 3.
//      -> each stat_grants entry=2, stat_stall=5.
//      -> stat_clr gives all counters 0.
//      -> a forced 70000-cycle stall reads 16'hFFFF.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC router output path.
//   DATA_WIDTH_DEF / NUM_VC_DEF : default flit width and VC count
//   STAT_W                      : width of the optional statistics counters
//   vc_idx_w()                  : bits needed to index a VC
//   out_state_e                 : output-register occupancy state
package noc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_VC_DEF     = 4;
  localparam int unsigned STAT_W         = 16;

  // A single VC still needs a 1-bit index field.
  function automatic int unsigned vc_idx_w(input int unsigned num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  localparam int unsigned VC_IDX_W_DEF = vc_idx_w(NUM_VC_DEF);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at (ptr+1) mod NUM_VC upward with wrap and grants the first set bit.
// Ports:
//   req     in  NUM_VC  request vector
//   ptr     in  IDX_W   index of the last granted requester
//   gnt     out NUM_VC  one-hot grant (all zero when no request)
//   gnt_idx out IDX_W   binary index of the grant (0 when no request)
//   any_req out 1       at least one request present
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_VC = NUM_VC_DEF,
  parameter int unsigned IDX_W  = vc_idx_w(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_VC-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  assign any_req = |req;

  // NUM_VC is a power of two, so IDX_W-bit addition wraps naturally. The last
  // candidate (i == NUM_VC) is ptr itself, giving it the lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= NUM_VC; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// Round-robin scheduler sharing one router output link between NUM_VC VC FIFOs.
// Picks one non-empty VC per cycle, pops its head flit and registers it onto a
// valid/ready output. Optional statistics are enabled with the macro
// VC_OUTPUT_ARBITER_STATS_EN.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   arb_en       1 allows new grants; 0 freezes grants, a held flit still drains
//   vc_empty     per-VC FIFO empty flags
//   vc_rd_data   per-VC head flits, VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vc_rd_en     one-hot pop strobe to the granted VC (combinational)
//   out_valid    output register holds a flit
//   out_data     registered flit
//   out_vc       VC index the registered flit came from
//   out_ready    downstream accepts the flit this cycle
//   stat_clr     (stats only) synchronous clear of all counters
//   stat_grants  (stats only) per-VC saturating grant counts, VC i at [i*16 +: 16]
//   stat_stall   (stats only) saturating count of out_valid & ~out_ready cycles
// The VC FIFOs must be reset together with this block: a flit held in the
// output register at reset is discarded.
module vc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_VC     = NUM_VC_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] vc_rd_data,
  output logic [NUM_VC-1:0]            vc_rd_en,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [vc_idx_w(NUM_VC)-1:0]  out_vc,
  input  logic                         out_ready
`ifdef VC_OUTPUT_ARBITER_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [NUM_VC*STAT_W-1:0]     stat_grants,
  output logic [STAT_W-1:0]            stat_stall
`endif
);

  localparam int unsigned IDX_W = vc_idx_w(NUM_VC);

  out_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        vc_q, vc_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;

  logic [NUM_VC-1:0]       req;
  logic [NUM_VC-1:0]       gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    any_req;
  logic                    load;
  logic [DATA_WIDTH-1:0]   head_data;

  assign req = ~vc_empty;

  rr_arbiter #(
    .NUM_VC (NUM_VC),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_vc    = vc_q;

  // Gated by rst so nothing is popped from the FIFOs while both are being reset.
  assign load     = ~rst & arb_en & any_req & (~out_valid | out_ready);
  assign vc_rd_en = load ? gnt : '0;

  // One-hot AND-OR mux of the granted head flit.
  always_comb begin
    head_data = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      head_data = head_data | ({DATA_WIDTH{gnt[i]}} & vc_rd_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    vc_d    = vc_q;
    ptr_d   = ptr_q;
    if (load) begin
      // Covers both a load into an empty register and a back-to-back drain+load.
      state_d = StFull;
      data_d  = head_data;
      vc_d    = gnt_idx;
      ptr_d   = gnt_idx;
    end else if (out_valid && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      vc_q    <= '0;
      ptr_q   <= IDX_W'(NUM_VC - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      vc_q    <= vc_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef VC_OUTPUT_ARBITER_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] grant_cnt_q [NUM_VC];
  logic [STAT_W-1:0] stall_cnt_q;
  logic              stall;

  assign stall = out_valid & ~out_ready;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        grant_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (vc_rd_en[i] && (grant_cnt_q[i] != STAT_MAX)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + STAT_W'(1);
        end
      end
      if (stall && (stall_cnt_q != STAT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      stat_grants[i*STAT_W +: STAT_W] = grant_cnt_q[i];
    end
  end

  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter with a small VC FIFO model driving
// vc_empty / vc_rd_data and popping on vc_rd_en.
module tb_vc_output_arbiter;

  localparam int NVC = 4;
  localparam int DW  = 32;

  logic                clk;
  logic                rst;
  logic                arb_en;
  logic [NVC-1:0]      vc_empty;
  logic [NVC*DW-1:0]   vc_rd_data;
  logic [NVC-1:0]      vc_rd_en;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [1:0]          out_vc;
  logic                out_ready;
`ifdef VC_OUTPUT_ARBITER_STATS_EN
  logic                stat_clr;
  logic [NVC*16-1:0]   stat_grants;
  logic [15:0]         stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  vc_output_arbiter #(
    .NUM_VC     (NVC),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .vc_empty   (vc_empty),
    .vc_rd_data (vc_rd_data),
    .vc_rd_en   (vc_rd_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_vc     (out_vc),
    .out_ready  (out_ready)
`ifdef VC_OUTPUT_ARBITER_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: wr_cnt written only by push(), rd_cnt only by the clocked block.
  logic [DW-1:0] mem [NVC][16];
  int            wr_cnt [NVC];
  int            rd_cnt [NVC];

  always @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (rst) rd_cnt[i] <= wr_cnt[i];
      else if (vc_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    end
  end

  always_comb begin
    vc_empty   = '0;
    vc_rd_data = '0;
    for (int i = 0; i < NVC; i++) begin
      vc_empty[i]          = (wr_cnt[i] == rd_cnt[i]);
      vc_rd_data[i*DW +: DW] = mem[i][rd_cnt[i][3:0]];
    end
  end

  task automatic push(input int vc, input logic [DW-1:0] d);
    mem[vc][wr_cnt[vc][3:0]] = d;
    wr_cnt[vc] = wr_cnt[vc] + 1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    arb_en    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    arb_en    = 1'b0;
    out_ready = 1'b0;
`ifdef VC_OUTPUT_ARBITER_STATS_EN
    stat_clr  = 1'b0;
`endif

    // ---- Test 1: reset values, then rotation across all VCs ----
    do_reset();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_vc", 64'(out_vc), 64'd0);
    check_eq("rst_rd_en", 64'(vc_rd_en), 64'd0);
    for (int v = 0; v < NVC; v++) begin
      push(v, 32'h100 + 32'(v * 16));
      push(v, 32'h101 + 32'(v * 16));
    end
    arb_en    = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq("t1_rd_en", 64'(vc_rd_en), 64'(1 << (k % 4)));
      tick();
      check_eq("t1_out_valid", 64'(out_valid), 64'd1);
      check_eq("t1_out_vc", 64'(out_vc), 64'(k % 4));
      check_eq("t1_out_data", 64'(out_data), 64'(32'h100 + 32'((k % 4) * 16 + k / 4)));
    end

    // ---- Test 2: single VC, back-to-back pops then empty ----
    do_reset();
    push(2, 32'hA0);
    push(2, 32'hA1);
    push(2, 32'hA2);
    arb_en    = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("t2_rd_en0", 64'(vc_rd_en), 64'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t2_out_valid", 64'(out_valid), 64'd1);
      check_eq("t2_out_data", 64'(out_data), 64'(32'hA0 + 32'(k)));
      check_eq("t2_out_vc", 64'(out_vc), 64'd2);
      check_eq("t2_rd_en", 64'(vc_rd_en), (k < 2) ? 64'b0100 : 64'b0000);
    end
    tick();
    check_eq("t2_drained", 64'(out_valid), 64'd0);

    // ---- Test 3: backpressure holds data and blocks pops ----
    do_reset();
    push(0, 32'hDEADBEEF);
    push(1, 32'h11);
    push(2, 32'h22);
    arb_en    = 1'b1;
    out_ready = 1'b0;
    #1;
    check_eq("t3_rd_en0", 64'(vc_rd_en), 64'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
      check_eq("t3_hold_data", 64'(out_data), 64'hDEADBEEF);
      check_eq("t3_hold_rd_en", 64'(vc_rd_en), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("t3_release_rd_en", 64'(vc_rd_en), 64'b0010);
    tick();
    check_eq("t3_next_data", 64'(out_data), 64'h11);
    check_eq("t3_next_vc", 64'(out_vc), 64'd1);

    // ---- Test 4: fairness between VC1 and VC3, arb_en freeze ----
    do_reset();
    push(1, 32'hB0);
    push(1, 32'hB1);
    push(3, 32'hD0);
    arb_en    = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("t4_gnt_vc1", 64'(vc_rd_en), 64'b0010);
    tick();
    check_eq("t4_data_b0", 64'(out_data), 64'hB0);
    check_eq("t4_gnt_vc3", 64'(vc_rd_en), 64'b1000);
    tick();
    check_eq("t4_vc_3", 64'(out_vc), 64'd3);
    check_eq("t4_gnt_vc1b", 64'(vc_rd_en), 64'b0010);
    tick();
    check_eq("t4_data_b1", 64'(out_data), 64'hB1);
    push(3, 32'hD1);
    arb_en = 1'b0;
    #1;
    check_eq("t4_frozen_rd_en", 64'(vc_rd_en), 64'd0);
    tick();
    check_eq("t4_drained", 64'(out_valid), 64'd0);
    check_eq("t4_frozen_rd_en2", 64'(vc_rd_en), 64'd0);
    tick();
    check_eq("t4_still_empty", 64'(out_valid), 64'd0);
    arb_en = 1'b1;
    #1;
    check_eq("t4_resume_vc3", 64'(vc_rd_en), 64'b1000);
    tick();
    check_eq("t4_data_d1", 64'(out_data), 64'hD1);

    // ---- Test 5: reset while holding a flit ----
    do_reset();
    push(2, 32'hE0);
    push(2, 32'hE1);
    push(3, 32'hF0);
    arb_en    = 1'b1;
    out_ready = 1'b0;
    #1;
    tick();
    check_eq("t5_held_valid", 64'(out_valid), 64'd1);
    check_eq("t5_held_vc", 64'(out_vc), 64'd2);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_rd_en", 64'(vc_rd_en), 64'd0);
    tick();
    check_eq("t5_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t5_rst_data", 64'(out_data), 64'd0);
    check_eq("t5_rst_vc", 64'(out_vc), 64'd0);
    rst = 1'b0;
    push(3, 32'hC3);
    push(1, 32'hC1);
    #1;
    check_eq("t5_first_gnt", 64'(vc_rd_en), 64'b0010);
    out_ready = 1'b1;
    tick();
    check_eq("t5_first_data", 64'(out_data), 64'hC1);
    check_eq("t5_first_vc", 64'(out_vc), 64'd1);

`ifdef VC_OUTPUT_ARBITER_STATS_EN
    // ---- Test 6: statistics counters ----
    do_reset();
    check_eq("t6_rst_grants", 64'(stat_grants), 64'd0);
    check_eq("t6_rst_stall", 64'(stat_stall), 64'd0);
    for (int v = 0; v < NVC; v++) begin
      push(v, 32'h600 + 32'(v));
      push(v, 32'h610 + 32'(v));
    end
    arb_en    = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    #1;
    check_eq("t6_grants_8", 64'(stat_grants), 64'h0002_0002_0002_0002);
    check_eq("t6_stall_0", 64'(stat_stall), 64'd0);
    repeat (5) tick();
    check_eq("t6_stall_5", 64'(stat_stall), 64'd5);
    check_eq("t6_grants_hold", 64'(stat_grants), 64'h0002_0002_0002_0002);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check_eq("t6_clr_grants", 64'(stat_grants), 64'd0);
    check_eq("t6_clr_stall", 64'(stat_stall), 64'd0);
    repeat (70000) tick();
    check_eq("t6_stall_sat", 64'(stat_stall), 64'hFFFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check_eq("t6_clr_priority", 64'(stat_stall), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
